// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;
  localparam int unsigned BYTE_CNT_W   = 2;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer plus bit-level framing FSM.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [1:0]        settle_q, settle_d;
  logic              prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              rx_s;
  logic              fall;

  assign rx_s = sync_q[1];
  // prev only arms after the synchronizer holds real line data, so a line
  // stuck low across reset is not mistaken for a start bit.
  assign fall = prev_q & ~rx_s;

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

  always_comb begin
    sync_d   = {sync_q[0], rx_i};
    settle_d = {settle_q[0], 1'b1};
    prev_d   = settle_q[1] & rx_s;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == BIT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          valid_d = rx_s;
          ferr_d  = ~rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      settle_q <= 2'b00;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles LE words into instruction memory, then releases the core.
// Optional trailing checksum word enabled by UART_PROG_LOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              rx_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              prog_done_o,
  output logic              core_rst_no,
  output logic              prog_err_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [BYTE_W-1:0]     rx_byte;
  logic                  rx_valid;
  logic                  rx_ferr;

  logic [31:0]           word_q, word_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  core_rst_q, core_rst_d;
  logic [31:0]           word_nxt;
  logic                  accept;
  logic                  word_done;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
  logic                  chk_q, chk_d;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  assign accept    = rx_valid & en_i & ~done_q;
  assign word_done = accept & (byte_cnt_q == BYTE_CNT_W'(3));

  // Little-endian lane insert of the incoming byte.
  always_comb begin
    word_nxt = word_q;
    case (byte_cnt_q)
      2'd0:    word_nxt[7:0]   = rx_byte;
      2'd1:    word_nxt[15:8]  = rx_byte;
      2'd2:    word_nxt[23:16] = rx_byte;
      default: word_nxt[31:24] = rx_byte;
    endcase
  end

  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    full_d     = full_q;
    done_d     = done_q;
    err_d      = err_q | rx_ferr;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    chk_d      = chk_q;
`endif
    // Address advances the cycle after the strobe; the top address saturates.
    if (we_q) begin
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + ADDR_W'(1);
    end
    if (accept) begin
      word_d     = word_nxt;
      byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
    end
    if (word_done) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      if (chk_q) begin
        done_d = 1'b1;
        if (word_nxt != sum_q) err_d = 1'b1;
      end else if (word_nxt == END_WORD) begin
        chk_d = 1'b1;
      end else if (full_q) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = word_nxt;
        sum_d   = sum_q + word_nxt;
      end
`else
      if (word_nxt == END_WORD) begin
        done_d = 1'b1;
      end else if (full_q) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = word_nxt;
      end
`endif
    end
    core_rst_d = done_d & ~err_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      full_q     <= full_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_done_o = done_q;
  assign prog_err_o  = err_q;
  assign core_rst_no = core_rst_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a byte-level reference model and write scoreboard.
module tb_uart_prog_loader;

  localparam int unsigned CPB  = 16;
  localparam int unsigned AW   = 2;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;
  localparam int unsigned AMAX = (1 << AW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          rx;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic          prog_done_o;
  logic          core_rst_no;
  logic          prog_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, advanced one whole byte at a time.
  logic [AW+31:0] exp_q[$];
  logic [31:0]    mword;
  int             mcnt;
  int unsigned    maddr;
  bit             mfull, mdone, merr, mchk;
  logic [31:0]    msum;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .END_WORD    (ENDW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .rx_i       (rx),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .prog_done_o(prog_done_o),
    .core_rst_no(core_rst_no),
    .prog_err_o (prog_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected write; a 2-cycle strobe shows up as an extra write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %h we %b", addr_o, wdata_o, we_o);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(addr_o), 32'(e[AW+31:32]));
        chk("write_data", wdata_o, e[31:0]);
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    mword = '0; mcnt = 0; maddr = 0;
    mfull = 0; mdone = 0; merr = 0; mchk = 0; msum = '0;
  endtask

  task automatic model_word(input logic [31:0] w);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    if (mchk) begin
      if (w != msum) merr = 1;
      mdone = 1;
      return;
    end
    if (w == ENDW) begin
      mchk = 1;
      return;
    end
`else
    if (w == ENDW) begin
      mdone = 1;
      return;
    end
`endif
    if (mfull) begin
      merr = 1;
    end else begin
      exp_q.push_back({AW'(maddr), w});
      msum = msum + w;
      if (maddr == AMAX) mfull = 1;
      else maddr++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!en || mdone) return;
    mword = mword | (32'(b) << (8 * mcnt));
    mcnt++;
    if (mcnt == 4) begin
      w = mword;
      mword = '0;
      mcnt = 0;
      model_word(w);
    end
  endtask

  task automatic hold(input logic v, input int unsigned cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) model_byte(b);
    else          merr = 1;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
    hold(1'b1, CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
  endtask

  task automatic checkpoint(input string name);
    repeat (CPB) @(negedge clk);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done"}, 32'(prog_done_o), 32'(mdone));
    chk({name, "_err"}, 32'(prog_err_o), 32'(merr));
    chk({name, "_core_rst"}, 32'(core_rst_no), 32'(mdone & ~merr));
    chk({name, "_addr"}, 32'(addr_o), 32'(maddr));
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk({name, "_rst_we"}, 32'(we_o), 32'd0);
    chk({name, "_rst_addr"}, 32'(addr_o), 32'd0);
    chk({name, "_rst_wdata"}, wdata_o, 32'd0);
    chk({name, "_rst_done"}, 32'(prog_done_o), 32'd0);
    chk({name, "_rst_core"}, 32'(core_rst_no), 32'd0);
    chk({name, "_rst_err"}, 32'(prog_err_o), 32'd0);
    model_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    en    = 1'b1;
    rx    = 1'b1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset("init");

    // Single word then END marker.
    send_word(32'h0000_0513);
    checkpoint("t1_word");
    chk("t1_wdata_lit", wdata_o, 32'h0000_0513);
    chk("t1_addr_lit", 32'(addr_o), 32'd1);
    send_word(ENDW);
    checkpoint("t1_end");
`ifndef UART_PROG_LOADER_CHECKSUM_EN
    chk("t1_done_lit", 32'(prog_done_o), 32'd1);
    chk("t1_core_lit", 32'(core_rst_no), 32'd1);
`endif

    // Three words, END, then a word that must be ignored (or consumed as checksum).
    do_reset("t2");
    send_word(32'hAABB_CCDD);
    send_word(32'h1122_3344);
    send_word(32'h0000_0013);
    send_word(ENDW);
    checkpoint("t2_end");
    chk("t2_addr_lit", 32'(addr_o), 32'd3);
    chk("t2_wdata_lit", wdata_o, 32'h0000_0013);
    send_word(32'h1234_5678);
    checkpoint("t2_after");

    // Short low glitch must not frame a byte or disturb alignment.
    do_reset("t3");
    hold(1'b0, 5);
    hold(1'b1, 3 * CPB);
    checkpoint("t3_glitch");
    send_word(32'hDEAD_BEEF);
    checkpoint("t3_word");
    chk("t3_wdata_lit", wdata_o, 32'hDEAD_BEEF);

    // Framing error is sticky and keeps the core in reset.
    do_reset("t4");
    send_byte(8'h13, 1'b0);
    checkpoint("t4_ferr");
    chk("t4_err_lit", 32'(prog_err_o), 32'd1);
    send_word(32'h0000_0513);
    send_word(ENDW);
    checkpoint("t4_end");
    chk("t4_core_lit", 32'(core_rst_no), 32'd0);

    // Reset in the middle of the second byte of a word.
    do_reset("t5");
    send_byte(8'h11, 1'b1);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    do_reset("t5_mid");
    send_word(32'h0000_0513);
    checkpoint("t5_word");
    chk("t5_wdata_lit", wdata_o, 32'h0000_0513);

    // Address overflow: fifth word is not written.
    do_reset("t6");
    for (int i = 0; i < 5; i++) send_word(32'h100 + 32'(i));
    checkpoint("t6_ovf");
    chk("t6_addr_lit", 32'(addr_o), 32'd3);
    chk("t6_err_lit", 32'(prog_err_o), 32'd1);
    send_word(ENDW);
    checkpoint("t6_end");

    // Bytes received while disabled are dropped; partial word is kept.
    do_reset("t7");
    send_byte(8'h44, 1'b1);
    en = 1'b0;
    send_byte(8'h99, 1'b1);
    en = 1'b1;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    checkpoint("t7_en");
    chk("t7_wdata_lit", wdata_o, 32'h7766_5544);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    do_reset("t8");
    send_word(32'd1);
    send_word(32'd2);
    send_word(ENDW);
    checkpoint("t8_end");
    chk("t8_notdone_lit", 32'(prog_done_o), 32'd0);
    send_word(32'd3);
    checkpoint("t8_sum");
    chk("t8_done_lit", 32'(prog_done_o), 32'd1);
    chk("t8_err_lit", 32'(prog_err_o), 32'd0);

    do_reset("t9");
    send_word(32'd1);
    send_word(32'd2);
    send_word(ENDW);
    send_word(32'd4);
    checkpoint("t9_sum");
    chk("t9_err_lit", 32'(prog_err_o), 32'd1);
    chk("t9_core_lit", 32'(core_rst_no), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
